// File: rtl/ram16x4_reader_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ram16x4_reader_pkg
//  Description : Shared types and constants for the 16x4 RAM sequential
//                reader. Build macro RAM16X4_SEQ_READER_PARITY_EN adds a
//                trailing even-parity bit to every serialized word.
//  Revision    : 1.0 - initial release
// ============================================================================
package ram16x4_reader_pkg;

    localparam int DEF_DATA_W = 4;
    localparam int DEF_ADDR_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic int bits_per_word(input int data_w);
`ifdef RAM16X4_SEQ_READER_PARITY_EN
        return data_w + 1;
`else
        return data_w;
`endif
    endfunction

    localparam int BITS_PER_WORD = bits_per_word(DEF_DATA_W);

endpackage
`default_nettype wire

// File: rtl/piso_shift_4bit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : piso_shift_4bit
//  Description : Parallel-load, right-shift register; sout is the LSB.
//  Revision    : 1.0 - initial release
// ============================================================================
module piso_shift_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             sout
);

    logic [WIDTH-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (load) begin
            r_q <= din;
        end else if (shift) begin
            r_q <= {1'b0, r_q[WIDTH-1:1]};
        end
    end

    assign sout = r_q[0];

endmodule
`default_nettype wire

// File: rtl/ram16x4_seq_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : ram16x4_seq_reader
//  Description : Walks an address range of a 16x4 RAM and streams each word
//                LSB-first over a valid/ready serial link. Optional parity
//                bit per word under RAM16X4_SEQ_READER_PARITY_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module ram16x4_seq_reader
    import ram16x4_reader_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd_en,
    input  logic [DATA_W-1:0] ram_data,
    output logic              ser_data,
    output logic              ser_valid,
    input  logic              ser_ready,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] c_S_IDLE  = ST_IDLE;
    localparam logic [1:0] c_S_FETCH = ST_FETCH;
    localparam logic [1:0] c_S_SHIFT = ST_SHIFT;
    localparam logic [1:0] c_S_DONE  = ST_DONE;

    localparam int                 c_BITS_PER_WORD = bits_per_word(DATA_W);
    localparam int                 c_CNT_W         = $clog2(c_BITS_PER_WORD);
    localparam logic [c_CNT_W-1:0] c_LAST_BIT      = c_CNT_W'(c_BITS_PER_WORD - 1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [ADDR_W-1:0]  r_addr_ptr;
    logic [ADDR_W-1:0]  r_last_addr;
    logic [c_CNT_W-1:0] r_bit_cnt;
    logic               w_accept;
    logic               w_word_end;
    logic               w_range_end;
    logic               w_shift_out;

    assign w_accept    = (r_state == c_S_SHIFT) && ser_ready;
    assign w_word_end  = w_accept && (r_bit_cnt == c_LAST_BIT);
    assign w_range_end = (r_addr_ptr == r_last_addr);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_S_IDLE:  if (start) w_state_nxt = c_S_FETCH;
            c_S_FETCH: w_state_nxt = c_S_SHIFT;
            c_S_SHIFT: if (w_word_end) w_state_nxt = w_range_end ? c_S_DONE : c_S_FETCH;
            c_S_DONE:  w_state_nxt = c_S_IDLE;
            default:   w_state_nxt = c_S_IDLE;
        endcase
    end

    // The pointer only moves on entry to FETCH, so it doubles as the held RAM address.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= c_S_IDLE;
            r_addr_ptr  <= '0;
            r_last_addr <= '0;
            r_bit_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == c_S_IDLE) && start) begin
                r_addr_ptr  <= first_addr;
                r_last_addr <= last_addr;
            end else if (w_word_end && !w_range_end) begin
                r_addr_ptr <= r_addr_ptr + ADDR_W'(1);
            end
            if (r_state == c_S_FETCH) begin
                r_bit_cnt <= '0;
            end else if (w_accept) begin
                r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
            end
        end
    end

    piso_shift_4bit #(
        .WIDTH (DATA_W)
    ) u_shift (
        .clk   (clk),
        .rst_n (reset),
        .load  (r_state == c_S_FETCH),
        .shift (w_accept),
        .din   (ram_data),
        .sout  (w_shift_out)
    );

`ifdef RAM16X4_SEQ_READER_PARITY_EN
    logic r_parity;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_parity <= 1'b0;
        end else if (r_state == c_S_FETCH) begin
            r_parity <= ^ram_data;
        end
    end

    assign ser_data = (r_bit_cnt == c_CNT_W'(DATA_W)) ? r_parity : w_shift_out;
`else
    assign ser_data = w_shift_out;
`endif

    assign ram_addr  = r_addr_ptr;
    assign ram_rd_en = (r_state == c_S_FETCH);
    assign ser_valid = (r_state == c_S_SHIFT);
    assign busy      = (r_state == c_S_FETCH) || (r_state == c_S_SHIFT);
    assign done      = (r_state == c_S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_ram16x4_seq_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_ram16x4_seq_reader
//  Description : Directed self-checking bench for ram16x4_seq_reader.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ram16x4_seq_reader;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] first_addr;
    logic [3:0] last_addr;
    logic [3:0] ram_addr;
    logic       ram_rd_en;
    logic [3:0] ram_data;
    logic       ser_data;
    logic       ser_valid;
    logic       ser_ready;
    logic       busy;
    logic       done;

    logic [3:0] mem [16];
    assign ram_data = mem[ram_addr];

    always #5 clk = ~clk;

    ram16x4_seq_reader u_dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .ram_addr   (ram_addr),
        .ram_rd_en  (ram_rd_en),
        .ram_data   (ram_data),
        .ser_data   (ser_data),
        .ser_valid  (ser_valid),
        .ser_ready  (ser_ready),
        .busy       (busy),
        .done       (done)
    );

    int          total = 0;
    int          bad   = 0;
    logic [63:0] bitvec;
    logic [63:0] fetchvec;
    int          nbits, nfetch, ndone, done_cyc, first_valid_cyc, stall_bad, stalled;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Cycle 1 is the cycle after the edge that samples start.
    task automatic run_burst(input logic [3:0] f, input logic [3:0] l,
                             input int stall_bit, input int stall_len, input int inj_mask);
        int   stall_left;
        logic held_d;
        bitvec = '0; fetchvec = '0;
        nbits = 0; nfetch = 0; ndone = 0; done_cyc = -1; first_valid_cyc = -1;
        stall_bad = 0; stalled = 0; stall_left = stall_len; held_d = 1'b0;
        first_addr = f; last_addr = l; start = 1'b1; ser_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= 80; cyc++) begin
            start = (cyc < 32) ? inj_mask[cyc] : 1'b0;
            if (start) begin
                first_addr = 4'd0;
                last_addr  = 4'd2;
            end
            if (ram_rd_en && nfetch < 16) begin
                fetchvec[4*nfetch +: 4] = ram_addr;
                nfetch++;
            end
            if (done) begin
                ndone++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (ser_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            ser_ready = 1'b1;
            if (ser_valid && nbits == stall_bit && stall_left > 0) begin
                if (stall_left == stall_len) held_d = ser_data;
                else if (ser_data !== held_d) stall_bad++;
                ser_ready = 1'b0;
                stall_left--;
                stalled++;
            end
            if (ser_valid && ser_ready && nbits < 64) begin
                bitvec[nbits] = ser_data;
                nbits++;
            end
            @(posedge clk); #1;
            if (done_cyc > 0 && cyc >= done_cyc + 3) break;
        end
        start = 1'b0;
        ser_ready = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 4'h0;
        reset = 1'b0; start = 1'b0; ser_ready = 1'b1;
        first_addr = 4'd0; last_addr = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {58'd0, ram_addr, ram_rd_en, ser_data, ser_valid, busy, done}, 64'd0);
        reset = 1'b1;
        @(posedge clk); #1;

`ifdef RAM16X4_SEQ_READER_PARITY_EN
        mem[7] = 4'b0111;
        run_burst(4'd7, 4'd7, -1, 0, 0);
        check("par7_nbits", nbits, 5);
        check("par7_bits", bitvec, 64'h17);
        check("par7_fetch", fetchvec, 64'h7);
        check("par7_done_cyc", done_cyc, 7);
        check("par7_ndone", ndone, 1);

        mem[3] = 4'b1011;
        run_burst(4'd3, 4'd3, -1, 0, 0);
        check("par3_bits", bitvec, 64'h1B);
        check("par3_done_cyc", done_cyc, 7);

        mem[0] = 4'h1; mem[1] = 4'h2; mem[2] = 4'h3;
        run_burst(4'd0, 4'd2, -1, 0, 0);
        check("par012_nbits", nbits, 15);
        check("par012_bits", bitvec, {5'b00011, 5'b10010, 5'b10001});
        check("par012_done_cyc", done_cyc, 19);
        check("par012_busy_after", busy, 0);
`else
        // Single word
        mem[3] = 4'b1011;
        run_burst(4'd3, 4'd3, -1, 0, 0);
        check("one_nfetch", nfetch, 1);
        check("one_fetch_addr", fetchvec, 64'h3);
        check("one_nbits", nbits, 4);
        check("one_bits", bitvec, 64'hB);
        check("one_first_valid", first_valid_cyc, 2);
        check("one_done_cyc", done_cyc, 6);
        check("one_ndone", ndone, 1);
        check("one_busy_after", busy, 0);

        // Three-word burst
        mem[0] = 4'h1; mem[1] = 4'h2; mem[2] = 4'h3;
        run_burst(4'd0, 4'd2, -1, 0, 0);
        check("b3_fetch", fetchvec, 64'h210);
        check("b3_nbits", nbits, 12);
        check("b3_bits", bitvec, 64'h321);
        check("b3_done_cyc", done_cyc, 16);
        check("b3_ndone", ndone, 1);

        // Wrap 14 -> 1
        mem[14] = 4'hA; mem[15] = 4'h5;
        run_burst(4'd14, 4'd1, -1, 0, 0);
        check("wrap_nfetch", nfetch, 4);
        check("wrap_fetch", fetchvec, 64'h10FE);
        check("wrap_nbits", nbits, 16);
        check("wrap_bits", bitvec, 64'h215A);
        check("wrap_done_cyc", done_cyc, 21);
        check("wrap_ndone", ndone, 1);

        // Five-cycle stall in the middle of word 2
        run_burst(4'd0, 4'd2, 5, 5, 0);
        check("stall_cycles", stalled, 5);
        check("stall_data_stable", stall_bad, 0);
        check("stall_nbits", nbits, 12);
        check("stall_bits", bitvec, 64'h321);
        check("stall_done_cyc", done_cyc, 21);

        // Async reset during SHIFT of word 2
        first_addr = 4'd0; last_addr = 4'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("abort_pre_state", {61'd0, busy, ser_valid, ram_addr == 4'd1}, 64'h7);
        reset = 1'b0;
        #1;
        check("abort_async_zero", {58'd0, ram_addr, ram_rd_en, ser_data, ser_valid, busy, done}, 64'd0);
        ndone = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (i == 2) reset = 1'b1;
            if (done || busy) ndone++;
        end
        check("abort_no_done", ndone, 0);

        // Starts while busy and during DONE are ignored
        mem[5] = 4'h6;
        run_burst(4'd5, 4'd5, -1, 0, (1 << 3) | (1 << 6));
        check("ign_nfetch", nfetch, 1);
        check("ign_fetch", fetchvec, 64'h5);
        check("ign_bits", bitvec, 64'h6);
        check("ign_done_cyc", done_cyc, 6);
        check("ign_ndone", ndone, 1);
        check("ign_busy_after", busy, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ram16x4_seq_reader.md
Name: ram16x4_seq_reader

Overview:
Read-side counterpart to the RAM_16x4 word-write path. On a start pulse it walks a programmable address range of the 16x4 RAM and fetches one word per address. Each word is shifted out LSB-first on a 1-bit serial stream with a valid/ready handshake. It sits between the RAM read port and any downstream serial consumer (UART TX, LED driver, test capture).

Parameters:
DATA_W, 4, RAM word width and bits serialized per word
ADDR_W, 4, RAM address width (16 words)

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle request to begin a read burst; ignored while busy=1
first_addr  input  ADDR_W  first address of burst, captured on accepted start
last_addr  input  ADDR_W  last address of burst, captured on accepted start
ram_addr  output  ADDR_W  address driven to RAM read port
ram_rd_en  output  1  high during the fetch cycle
ram_data  input  DATA_W  RAM read data, combinational from ram_addr, sampled at end of fetch cycle
ser_data  output  1  serial data bit
ser_valid  output  1  ser_data is valid
ser_ready  input  1  consumer accepts bit when ser_valid && ser_ready at a rising edge
busy  output  1  burst in progress (FETCH or SHIFT)
done  output  1  one-cycle pulse after last bit of burst accepted

Behaviour:
- Reset (asserted low, async): state=IDLE; ram_addr=0, ram_rd_en=0, ser_data=0, ser_valid=0, busy=0, done=0. Internal address, shift and bit counters clear. Reset mid-burst aborts immediately; no done pulse.
- FSM states: IDLE, FETCH, SHIFT, DONE.
- IDLE: start=1 captures first_addr/last_addr and loads addr_ptr=first_addr -> FETCH.
- FETCH (1 cycle): ram_addr=addr_ptr, ram_rd_en=1, busy=1. At the clock edge, ram_data is loaded into the shift register, bit_cnt=0 -> SHIFT.
- SHIFT: ser_valid=1 and ser_data=shift_reg[0].
  - On ser_valid && ser_ready: shift right, bit_cnt++.
  - While ser_ready=0: ser_data and ser_valid are held stable.
  - After bit DATA_W-1 is accepted: if addr_ptr==last_addr -> DONE; else addr_ptr=addr_ptr+1 (mod 2^ADDR_W) -> FETCH.
- DONE (1 cycle): done=1, busy=0, ser_valid=0 -> IDLE.
- Latency: start at edge N -> FETCH in cycle N+1 -> first bit valid in cycle N+2.
- Throughput with ser_ready tied high: DATA_W+1 cycles per word.
- Wrap-around: last_addr<first_addr wraps 15->0. Example: first=14, last=1 reads 14, 15, 0, 1. first==last reads exactly one word.
- start while busy: ignored, no effect on the captured range.
- start in the DONE cycle: ignored. start is accepted only in IDLE.
- ram_addr holds its last value outside FETCH. ram_rd_en is low outside FETCH.

Optional Feature:
Macro RAM16X4_SEQ_READER_PARITY_EN.
- Defined: after the DATA_W data bits of each word, one extra even-parity bit (XOR of the 4 data bits) is sent with the same handshake. Per-word cost becomes DATA_W+2 cycles at full rate.
- Undefined: no parity bit; bit counter terminates at DATA_W-1; no parity logic is synthesized.

Decomposition:
- Package ram16x4_reader_pkg holds:
  - state enum (IDLE, FETCH, SHIFT, DONE)
  - DATA_W/ADDR_W defaults
  - BITS_PER_WORD constant (DATA_W, or DATA_W+1 under the macro)
- One sub-module: piso_shift_4bit, a parallel-load, right-shift register with async active-low reset, load and shift enables. The top holds the FSM, address pointer and bit counter.

Test Plan:
- Preload RAM[3]=4'b1011; start, first=3, last=3, ser_ready=1 -> rd_en high 1 cycle with ram_addr=3; ser_data 1,1,0,1 on consecutive cycles; done pulses once, 6 cycles after start edge; busy low afterwards.
- RAM[0..2]=4'h1,4'h2,4'h3; burst 0..2 with ser_ready=1 -> 12 bits 1000 0100 1100; one FETCH per word; done once.
- Wrap: first=14, last=1 -> ram_addr sequence 14, 15, 0, 1 on FETCH cycles; 16 bits out; done once.
- Backpressure: hold ser_ready=0 for 5 cycles mid-word -> ser_data/ser_valid stable throughout; no bit lost or duplicated; completion delayed by exactly 5 cycles.
- Drive reset low during SHIFT of word 2 -> all outputs 0 asynchronously; no done pulse. After release, start with first=5, last=5 runs normally. start pulsed while busy -> ignored, range unchanged.
- With RAM16X4_SEQ_READER_PARITY_EN and RAM[7]=4'b0111 -> bits 1,1,1,0 then parity 1; done 7 cycles after start.
